// File: rtl/cache_controller_param.sv
// cache_controller_param: set-associative, write-through, no-write-allocate
// read cache sitting between the MEM stage and a 64-bit-line SRAM.
//
// Parameters
//   WAYS  associativity (power of two, 1..8)
//   SETS  sets per way  (power of two, 4..1024)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   address, writeData            MEM-stage byte address / store data
//   MEM_R_EN, MEM_W_EN            load / store request (held until ready)
//   rdata, ready                  load data / request complete
//   sram_address, sram_write_data SRAM request address / store data
//   sram_read_en, sram_write_en   SRAM request strobes
//   sram_read_data, sram_ready    64-bit line returned / SRAM done
//   hit_count, miss_count         completed read hits / misses
//                                 (only when CACHE_STATS_EN is defined)
//
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
module cache_controller_param #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  output logic        sram_read_en,
  output logic        sram_write_en,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 29 - IDX_W;
  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state_q, state_d;

  // Storage: valid bits are reset, tag/data arrays are not.
  logic [SETS-1:0]  valid_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [63:0]      data_q  [WAYS][SETS];

  // Request captured when leaving IDLE so a dropped or changed request
  // cannot corrupt the SRAM transaction or the fill.
  logic [31:0] req_addr, req_wdata;
  logic        capture;

  logic [IDX_W-1:0] cur_idx, rq_idx;
  logic [TAG_W-1:0] cur_tag, rq_tag;

  assign cur_idx = address[2+IDX_W:3];
  assign cur_tag = address[31:3+IDX_W];
  assign rq_idx  = req_addr[2+IDX_W:3];
  assign rq_tag  = req_addr[31:3+IDX_W];

  // Lookup on the live address (IDLE hit path)
  logic        hit_any;
  logic [63:0] hit_line;

  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][cur_idx] && (tag_q[w][cur_idx] == cur_tag)) begin
        hit_any  = 1'b1;
        hit_line = data_q[w][cur_idx];
      end
    end
  end

  // Victim choice and write-through invalidate match on the captured address
  logic [PTR_W-1:0] ptr_way, vic_way;
  logic             all_valid;
  logic [WAYS-1:0]  inv_vec;

  always_comb begin
    vic_way   = ptr_way;
    all_valid = 1'b1;
    inv_vec   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[w][rq_idx] && all_valid) begin
        vic_way   = PTR_W'(w);
        all_valid = 1'b0;
      end
      inv_vec[w] = valid_q[w][rq_idx] && (tag_q[w][rq_idx] == rq_tag);
    end
  end

  // FSM next state and outputs
  logic fill_en, inval_en;

  always_comb begin
    state_d         = state_q;
    ready           = 1'b0;
    rdata           = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_address    = '0;
    sram_write_data = '0;
    fill_en         = 1'b0;
    inval_en        = 1'b0;
    capture         = 1'b0;
    if (rst) begin
      ready = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MEM_W_EN) begin
            state_d = WR_THRU;
            capture = 1'b1;
          end else if (MEM_R_EN) begin
            if (hit_any) begin
              ready = 1'b1;
              rdata = address[2] ? hit_line[63:32] : hit_line[31:0];
            end else begin
              state_d = RD_MISS;
              capture = 1'b1;
            end
          end else begin
            ready = 1'b1;
          end
        end
        RD_MISS: begin
          sram_read_en = 1'b1;
          sram_address = {req_addr[31:3], 3'b000};
          if (sram_ready) begin
            state_d = IDLE;
            ready   = 1'b1;
            rdata   = req_addr[2] ? sram_read_data[63:32] : sram_read_data[31:0];
            // A dropped request still finishes the SRAM read, but the
            // line is not installed.
            fill_en = MEM_R_EN && !MEM_W_EN;
          end
        end
        WR_THRU: begin
          sram_write_en   = 1'b1;
          sram_address    = req_addr;
          sram_write_data = req_wdata;
          if (sram_ready) begin
            state_d  = IDLE;
            ready    = 1'b1;
            inval_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (capture) begin
        req_addr  <= address;
        req_wdata <= writeData;
      end
      if (fill_en) begin
        valid_q[vic_way][rq_idx] <= 1'b1;
      end
      if (inval_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (inv_vec[w]) valid_q[w][rq_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[vic_way][rq_idx]  <= rq_tag;
      data_q[vic_way][rq_idx] <= sram_read_data;
    end
  end

  // Round-robin pointer only moves when a valid line was evicted
  if (WAYS > 1) begin : g_ptr
    logic [PTR_W-1:0] ptr_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          ptr_q[s] <= '0;
        end
      end else if (fill_en && all_valid) begin
        ptr_q[rq_idx] <= ptr_q[rq_idx] + 1'b1;
      end
    end

    assign ptr_way = ptr_q[rq_idx];
  end else begin : g_no_ptr
    assign ptr_way = '0;
  end

`ifdef CACHE_STATS_EN
  logic hit_evt;
  assign hit_evt = !rst && (state_q == IDLE) && MEM_R_EN && !MEM_W_EN && hit_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt) hit_count  <= hit_count + 32'd1;
      if (fill_en) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
